// File: rtl/xres_filter_pkg.sv
// Shared types and constants for the reset-pad filter array.
//   state_e     : per-channel qualification FSM states
//   CNT_W       : width of the per-channel qualify/stretch counter and the warning counter
//   DEF_*       : parameter defaults used by xres_filter_array and xres_filter_chan
package xres_filter_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int DEF_NCH          = 2;
  localparam int DEF_FILT_CYC     = 16;
  localparam int DEF_WARN_MIN_CYC = 4;
  localparam int DEF_STRETCH_CYC  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUAL    = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_STRETCH = 2'd3
  } state_e;

endpackage

// File: rtl/xres_filter_chan.sv
// One reset-pad channel: source mux, 2-flop synchronizer, qualify/stretch FSM,
// warning pulse and saturating warning counter.
//   clk, reset   : clock, synchronous active-high reset
//   pad_n        : raw active-low pad level (async)
//   filt_in      : externally filtered active-low level (async)
//   inp_sel      : 0 = qualify pad_n here, 1 = take filt_in without qualification
//   enable       : 0 forces the channel idle (reset released)
//   clear_warn   : clears the warning counter
//   xres_n       : registered filtered active-low reset
//   xres_n_nxt   : next-state value of xres_n, for the array-wide AND
//   warn_pulse   : one-cycle pulse per rejected pulse of width >= WARN_MIN_CYC
//   warn_cnt     : saturating count of warn_pulse
module xres_filter_chan
  import xres_filter_pkg::*;
#(
  parameter int FILT_CYC     = DEF_FILT_CYC,
  parameter int WARN_MIN_CYC = DEF_WARN_MIN_CYC,
  parameter int STRETCH_CYC  = DEF_STRETCH_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pad_n,
  input  logic             filt_in,
  input  logic             inp_sel,
  input  logic             enable,
  input  logic             clear_warn,
  output logic             xres_n,
  output logic             xres_n_nxt,
  output logic             warn_pulse,
  output logic [CNT_W-1:0] warn_cnt
);

  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CYC - 1);
  localparam logic [CNT_W-1:0] WARN_MIN  = CNT_W'(WARN_MIN_CYC);
  localparam logic [CNT_W-1:0] STR_LAST  = CNT_W'(STRETCH_CYC);

  logic             sync1, s;
  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             warn_nxt;

  // Source is chosen before synchronizing so both paths share the same metastability guard.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
    end else begin
      sync1 <= inp_sel ? filt_in : pad_n;
      s     <= sync1;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    warn_nxt  = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!s) begin
            if (inp_sel) begin
              state_nxt = ST_ASSERT;
              cnt_nxt   = '0;
            end else begin
              state_nxt = ST_QUAL;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ST_QUAL: begin
          // Switching to the bypass source abandons qualification silently.
          if (inp_sel) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (!s) begin
            if (cnt == FILT_LAST) begin
              state_nxt = ST_ASSERT;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            warn_nxt  = (cnt >= WARN_MIN);
          end
        end
        ST_ASSERT: begin
          if (s) begin
            state_nxt = ST_STRETCH;
            cnt_nxt   = CNT_W'(1);
          end
        end
        ST_STRETCH: begin
          if (!s) begin
            state_nxt = ST_ASSERT;
            cnt_nxt   = '0;
          end else if (cnt == STR_LAST) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign xres_n_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_QUAL);

  // NOTE: only control state is reset; there is no memory here that would need exemption.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      xres_n     <= 1'b1;
      warn_pulse <= 1'b0;
      warn_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      xres_n     <= xres_n_nxt;
      warn_pulse <= warn_nxt;
      // The counter accumulates the registered pulse, so a clear in the same
      // cycle as a visible pulse still keeps that one event.
      if (clear_warn) begin
        warn_cnt <= {{(CNT_W-1){1'b0}}, warn_pulse};
      end else if (warn_pulse && (warn_cnt != CNT_MAX)) begin
        warn_cnt <= warn_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/xres_filter_array.sv
// Array of independent reset-pad filter channels plus an array-wide reset.
//   clk, reset    : clock, synchronous active-high reset
//   pad_n_i       : [NCH] raw active-low pad levels
//   filt_in_i     : [NCH] externally filtered active-low levels
//   inp_sel_i     : [NCH] source select per channel (1 = bypass qualification)
//   enable_i      : [NCH] channel enable
//   clear_warn_i  : clears all warning counters
//   xres_n_o      : [NCH] filtered active-low resets
//   xres_any_n_o  : AND of all channel resets, registered with the same latency
//   warn_pulse_o  : [NCH] rejected-pulse warnings
//   warn_cnt_o    : [8*NCH] saturating warning counts, channel k at [8k+7:8k]
module xres_filter_array
  import xres_filter_pkg::*;
#(
  parameter int NCH          = DEF_NCH,
  parameter int FILT_CYC     = DEF_FILT_CYC,
  parameter int WARN_MIN_CYC = DEF_WARN_MIN_CYC,
  parameter int STRETCH_CYC  = DEF_STRETCH_CYC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     pad_n_i,
  input  logic [NCH-1:0]     filt_in_i,
  input  logic [NCH-1:0]     inp_sel_i,
  input  logic [NCH-1:0]     enable_i,
  input  logic               clear_warn_i,
  output logic [NCH-1:0]     xres_n_o,
  output logic               xres_any_n_o,
  output logic [NCH-1:0]     warn_pulse_o,
  output logic [8*NCH-1:0]   warn_cnt_o
);

  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("xres_filter_array: NCH must be 1..8");
  end
  if (FILT_CYC < 2 || FILT_CYC > 255) begin : g_bad_filt
    $error("xres_filter_array: FILT_CYC must be 2..255");
  end
  if (WARN_MIN_CYC < 1 || WARN_MIN_CYC >= FILT_CYC) begin : g_bad_warn
    $error("xres_filter_array: WARN_MIN_CYC must be 1..FILT_CYC-1");
  end
  if (STRETCH_CYC < 1 || STRETCH_CYC > 255) begin : g_bad_stretch
    $error("xres_filter_array: STRETCH_CYC must be 1..255");
  end

  logic [NCH-1:0] xres_n_nxt;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    xres_filter_chan #(
      .FILT_CYC     (FILT_CYC),
      .WARN_MIN_CYC (WARN_MIN_CYC),
      .STRETCH_CYC  (STRETCH_CYC)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .pad_n      (pad_n_i[k]),
      .filt_in    (filt_in_i[k]),
      .inp_sel    (inp_sel_i[k]),
      .enable     (enable_i[k]),
      .clear_warn (clear_warn_i),
      .xres_n     (xres_n_o[k]),
      .xres_n_nxt (xres_n_nxt[k]),
      .warn_pulse (warn_pulse_o[k]),
      .warn_cnt   (warn_cnt_o[8*k +: 8])
    );
  end

  // Built from next-state values so the summary reset lines up with xres_n_o.
  always_ff @(posedge clk) begin
    if (reset) begin
      xres_any_n_o <= 1'b1;
    end else begin
      xres_any_n_o <= &xres_n_nxt;
    end
  end

endmodule

// File: tb/tb_xres_filter_array.sv
module tb_xres_filter_array;
  localparam int NCH  = 2;
  localparam int FILT = 16;
  localparam int WMIN = 4;
  localparam int STR  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   pad_n_i, filt_in_i, inp_sel_i, enable_i;
  logic             clear_warn_i;
  logic [NCH-1:0]   xres_n_o;
  logic             xres_any_n_o;
  logic [NCH-1:0]   warn_pulse_o;
  logic [8*NCH-1:0] warn_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xres_filter_array #(
    .NCH(NCH), .FILT_CYC(FILT), .WARN_MIN_CYC(WMIN), .STRETCH_CYC(STR)
  ) dut (
    .clk(clk), .reset(reset), .pad_n_i(pad_n_i), .filt_in_i(filt_in_i),
    .inp_sel_i(inp_sel_i), .enable_i(enable_i), .clear_warn_i(clear_warn_i),
    .xres_n_o(xres_n_o), .xres_any_n_o(xres_any_n_o),
    .warn_pulse_o(warn_pulse_o), .warn_cnt_o(warn_cnt_o)
  );

  // Behavioural model: the channel is "in reset" after FILT consecutive low
  // samples (or any low sample on the bypass source) and leaves it after more
  // than STR consecutive high samples. Low runs that end early are rejected.
  bit m_sync1 [NCH];
  bit m_s     [NCH];
  bit m_in_rst[NCH];
  int m_low   [NCH];
  int m_high  [NCH];
  bit m_warn  [NCH];
  int m_wcnt  [NCH];

  task automatic model_edge();
    for (int k = 0; k < NCH; k++) begin
      bit w;
      w = 1'b0;
      if (reset) begin
        m_sync1[k] = 1'b1; m_s[k] = 1'b1; m_in_rst[k] = 1'b0;
        m_low[k] = 0; m_high[k] = 0; m_warn[k] = 1'b0; m_wcnt[k] = 0;
      end else begin
        if (clear_warn_i) m_wcnt[k] = m_warn[k] ? 1 : 0;
        else if (m_warn[k] && m_wcnt[k] < 255) m_wcnt[k]++;
        if (!enable_i[k]) begin
          m_in_rst[k] = 1'b0; m_low[k] = 0; m_high[k] = 0;
        end else if (!m_in_rst[k]) begin
          if (m_low[k] > 0 && inp_sel_i[k]) begin
            m_low[k] = 0;
          end else if (!m_s[k]) begin
            if (inp_sel_i[k]) begin
              m_in_rst[k] = 1'b1;
            end else begin
              m_low[k]++;
              if (m_low[k] == FILT) begin
                m_in_rst[k] = 1'b1; m_low[k] = 0;
              end
            end
          end else begin
            w = (m_low[k] >= WMIN);
            m_low[k] = 0;
          end
        end else begin
          if (m_s[k]) begin
            m_high[k]++;
            if (m_high[k] > STR) begin
              m_in_rst[k] = 1'b0; m_high[k] = 0;
            end
          end else begin
            m_high[k] = 0;
          end
        end
        m_warn[k] = w;
        m_s[k]    = m_sync1[k];
        m_sync1[k] = inp_sel_i[k] ? filt_in_i[k] : pad_n_i[k];
      end
    end
  endtask

  function automatic logic [NCH-1:0] exp_xres();
    for (int k = 0; k < NCH; k++) exp_xres[k] = !m_in_rst[k];
  endfunction

  function automatic logic [NCH-1:0] exp_warn();
    for (int k = 0; k < NCH; k++) exp_warn[k] = m_warn[k];
  endfunction

  function automatic logic [8*NCH-1:0] exp_cnt();
    for (int k = 0; k < NCH; k++) exp_cnt[8*k +: 8] = 8'(m_wcnt[k]);
  endfunction

  // Advance one clock: model first (pre-edge inputs), then sample the DUT 1 ns after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    reset = 1'b0; pad_n_i = '1; filt_in_i = '1; inp_sel_i = '0;
    enable_i = '1; clear_warn_i = 1'b0;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    step(); step();
    checks++;
    if (xres_n_o !== '1 || xres_any_n_o !== 1'b1) begin
      errors++; $display("FAIL reset_xres: xres_n=%b any=%b want all ones", xres_n_o, xres_any_n_o);
    end
    checks++;
    if (warn_pulse_o !== '0 || warn_cnt_o !== '0) begin
      errors++; $display("FAIL reset_warn: pulse=%b cnt=%h want 0", warn_pulse_o, warn_cnt_o);
    end
    reset = 1'b0;
    settle(3);
  endtask

  task automatic test_filter_assert();
    int first_low = -1, low_cnt = 0, warns = 0;
    for (int c = 1; c <= 45; c++) begin
      pad_n_i[0] = (c <= 20) ? 1'b0 : 1'b1;
      step();
      if (!xres_n_o[0]) begin
        low_cnt++;
        if (first_low < 0) first_low = c;
      end
      if (warn_pulse_o[0]) warns++;
      checks++;
      if (xres_n_o !== exp_xres() || xres_any_n_o !== &exp_xres()) begin
        errors++; $display("FAIL filter_model c=%0d: xres=%b any=%b want %b", c, xres_n_o, xres_any_n_o, exp_xres());
      end
    end
    checks++;
    if (first_low != 18) begin
      errors++; $display("FAIL filter_first_low: got %0d want 18", first_low);
    end
    checks++;
    if (low_cnt != 13) begin
      errors++; $display("FAIL filter_low_len: got %0d want 13", low_cnt);
    end
    checks++;
    if (warns != 0) begin
      errors++; $display("FAIL filter_warn: got %0d want 0", warns);
    end
  endtask

  task automatic test_reject();
    int warns = 0, lows = 0;
    clear_warn_i = 1'b1; step(); clear_warn_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      pad_n_i[0] = (c <= 6) ? 1'b0 : 1'b1;
      step();
      if (warn_pulse_o[0]) warns++;
      if (!xres_n_o[0]) lows++;
      checks++;
      if (warn_pulse_o !== exp_warn()) begin
        errors++; $display("FAIL reject6_pulse c=%0d: got %b want %b", c, warn_pulse_o, exp_warn());
      end
    end
    checks++;
    if (warns != 1 || lows != 0) begin
      errors++; $display("FAIL reject6: warns=%0d lows=%0d want 1 and 0", warns, lows);
    end
    checks++;
    if (warn_cnt_o[7:0] !== 8'd1) begin
      errors++; $display("FAIL reject6_cnt: got %0d want 1", warn_cnt_o[7:0]);
    end
    warns = 0;
    for (int c = 1; c <= 12; c++) begin
      pad_n_i[0] = (c <= 2) ? 1'b0 : 1'b1;
      step();
      if (warn_pulse_o[0]) warns++;
    end
    checks++;
    if (warns != 0 || warn_cnt_o[7:0] !== 8'd1) begin
      errors++; $display("FAIL reject2: warns=%0d cnt=%0d want 0 and 1", warns, warn_cnt_o[7:0]);
    end
  endtask

  task automatic test_bypass();
    int first_low = -1, low_cnt = 0, any_low = 0;
    inp_sel_i[1] = 1'b1;
    settle(4);
    for (int c = 1; c <= 20; c++) begin
      filt_in_i[1] = (c <= 3) ? 1'b0 : 1'b1;
      step();
      if (!xres_n_o[1]) begin
        low_cnt++;
        if (first_low < 0) first_low = c;
      end
      if (!xres_any_n_o) any_low++;
      checks++;
      if (xres_n_o !== exp_xres() || xres_any_n_o !== &exp_xres()) begin
        errors++; $display("FAIL bypass_model c=%0d: xres=%b any=%b want %b", c, xres_n_o, xres_any_n_o, exp_xres());
      end
    end
    checks++;
    if (first_low != 3 || low_cnt != 11 || any_low != 11) begin
      errors++; $display("FAIL bypass_timing: first=%0d len=%0d any=%0d want 3 11 11", first_low, low_cnt, any_low);
    end
    inp_sel_i[1] = 1'b0;
    settle(4);
  endtask

  task automatic test_stretch_reassert();
    int glitches = 0;
    for (int c = 1; c <= 70; c++) begin
      pad_n_i[0] = ((c <= 20) || (c >= 25 && c <= 44)) ? 1'b0 : 1'b1;
      step();
      if (c >= 18 && c <= 44 && xres_n_o[0]) glitches++;
      checks++;
      if (xres_n_o !== exp_xres()) begin
        errors++; $display("FAIL stretch_model c=%0d: got %b want %b", c, xres_n_o, exp_xres());
      end
    end
    checks++;
    if (glitches != 0 || xres_n_o[0] !== 1'b1) begin
      errors++; $display("FAIL stretch_reassert: glitches=%0d end=%b want 0 and 1", glitches, xres_n_o[0]);
    end
  endtask

  task automatic test_warn_saturate();
    int warns = 0;
    bit found = 1'b0;
    for (int p = 0; p < 300; p++) begin
      for (int c = 0; c < 10; c++) begin
        pad_n_i[1] = (c < 5) ? 1'b0 : 1'b1;
        step();
        if (warn_pulse_o[1]) warns++;
      end
    end
    settle(3);
    checks++;
    if (warns != 300 || warn_cnt_o[15:8] !== 8'd255) begin
      errors++; $display("FAIL warn_saturate: pulses=%0d cnt=%0d want 300 and 255", warns, warn_cnt_o[15:8]);
    end
    checks++;
    if (warn_cnt_o !== exp_cnt()) begin
      errors++; $display("FAIL warn_sat_model: got %h want %h", warn_cnt_o, exp_cnt());
    end
    for (int c = 0; c < 25 && !found; c++) begin
      pad_n_i[1] = (c < 6) ? 1'b0 : 1'b1;
      step();
      if (warn_pulse_o[1]) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL warn_wait: no warn_pulse within 25 cycles");
    end
    clear_warn_i = 1'b1;
    step();
    clear_warn_i = 1'b0;
    checks++;
    if (warn_cnt_o !== {8'd1, 8'd0}) begin
      errors++; $display("FAIL warn_clear: got %h want 0100", warn_cnt_o);
    end
    pad_n_i[1] = 1'b1;
    settle(4);
  endtask

  task automatic test_sel_change();
    int warns = 0, lows = 0;
    for (int c = 1; c <= 20; c++) begin
      pad_n_i[0]   = (c <= 8) ? 1'b0 : 1'b1;
      inp_sel_i[0] = (c >= 10 && c <= 16) ? 1'b1 : 1'b0;
      step();
      if (warn_pulse_o[0]) warns++;
      if (!xres_n_o[0]) lows++;
      checks++;
      if (warn_pulse_o !== exp_warn() || xres_n_o !== exp_xres()) begin
        errors++; $display("FAIL selchg_model c=%0d: pulse=%b xres=%b want %b %b", c, warn_pulse_o, xres_n_o, exp_warn(), exp_xres());
      end
    end
    checks++;
    if (warns != 0 || lows != 0) begin
      errors++; $display("FAIL sel_change: warns=%0d lows=%0d want 0 0", warns, lows);
    end
  endtask

  task automatic test_reset_enable();
    int highs = 0, warns = 0;
    for (int c = 1; c <= 19; c++) begin
      pad_n_i[0] = 1'b0;
      step();
    end
    checks++;
    if (xres_n_o[0] !== 1'b0) begin
      errors++; $display("FAIL rst_pre_assert: got %b want 0", xres_n_o[0]);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (xres_n_o !== '1 || xres_any_n_o !== 1'b1 || warn_cnt_o !== '0) begin
      errors++; $display("FAIL rst_mid_assert: xres=%b any=%b cnt=%h want 11 1 0", xres_n_o, xres_any_n_o, warn_cnt_o);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      if (xres_n_o[0]) highs++;
    end
    checks++;
    if (highs != 10) begin
      errors++; $display("FAIL rst_no_stretch: high cycles=%0d want 10", highs);
    end
    pad_n_i[0] = 1'b1;
    settle(30);
    for (int c = 1; c <= 25; c++) begin
      pad_n_i[1]  = (c <= 8) ? 1'b0 : 1'b1;
      enable_i[1] = (c == 9) ? 1'b0 : 1'b1;
      step();
      if (warn_pulse_o[1]) warns++;
      if (c == 9) begin
        checks++;
        if (xres_n_o[1] !== 1'b1) begin
          errors++; $display("FAIL enable_drop: got %b want 1", xres_n_o[1]);
        end
      end
    end
    checks++;
    if (warns != 0) begin
      errors++; $display("FAIL enable_warn: got %0d want 0", warns);
    end
  endtask

  task automatic test_random();
    int pad_hold[NCH];
    int filt_hold[NCH];
    for (int k = 0; k < NCH; k++) begin
      pad_hold[k] = 0; filt_hold[k] = 0;
    end
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NCH; k++) begin
        if (pad_hold[k] == 0) begin
          pad_n_i[k] = 1'($urandom_range(0, 1)); pad_hold[k] = $urandom_range(1, 24);
        end else pad_hold[k]--;
        if (filt_hold[k] == 0) begin
          filt_in_i[k] = 1'($urandom_range(0, 1)); filt_hold[k] = $urandom_range(1, 14);
        end else filt_hold[k]--;
        if ($urandom_range(0, 59) == 0) inp_sel_i[k] = ~inp_sel_i[k];
        enable_i[k] = ($urandom_range(0, 79) != 0);
      end
      clear_warn_i = ($urandom_range(0, 49) == 0);
      reset        = ($urandom_range(0, 399) == 0);
      step();
      checks++;
      if (xres_n_o !== exp_xres() || xres_any_n_o !== &exp_xres()) begin
        errors++; $display("FAIL rand_xres c=%0d: xres=%b any=%b want %b", c, xres_n_o, xres_any_n_o, exp_xres());
      end
      checks++;
      if (warn_pulse_o !== exp_warn() || warn_cnt_o !== exp_cnt()) begin
        errors++; $display("FAIL rand_warn c=%0d: pulse=%b cnt=%h want %b %h", c, warn_pulse_o, warn_cnt_o, exp_warn(), exp_cnt());
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_filter_assert();
    test_reject();
    test_bypass();
    test_stretch_reassert();
    test_warn_saturate();
    test_sel_change();
    test_reset_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
